picobello_top_fixture: RTL and testbench
========================================

# picobello_top_fixture

Synthesizable boot/preload sequencer that models the Picobello top-level test fixture's control flow. It drives the chip boot-mode pins, waits for chip reset release, and dispatches loader operations (init, Snitch preload, Cheshire run) to an external loader agent over a one-op-at-a-time handshake. It then polls the end-of-computation (EOC) register, waits for the UART to go idle, and reports the exit code. It sits between the bench control and the JTAG/serial-link/UART/fast-load VIP agents.

## Interface
- `EocAddr`, default `64'h0300_0008`: address of the EOC scratch register.
- `PollGap`, default `16`: idle cycles between EOC polls; minimum 1.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  one-cycle pulse that starts a run; sampled only in IDLE.
- `boot_mode_i`  in  2  0 = idle/preload, 1 = SD card (unsupported), 2/3 = autonomous.
- `preload_mode_i`  in  2  0 = JTAG, 1 = serial link, 2 = UART, 3 = fast.
- `snitch_preload_i`  in  1  a Snitch binary must be preloaded.
- `boot_mode_o`  out  2  chip boot-mode pins.
- `dut_rst_ni`  in  1  chip reset as seen by the chip; synchronised internally with 2 flops.
- `ld_req_o`  out  1  loader operation request.
- `ld_op_o`  out  2  operation: 0 = INIT, 1 = SNITCH_PRELOAD, 2 = RUN.
- `ld_if_o`  out  2  transport agent; same encoding as `preload_mode_i`.
- `ld_done_i`  in  1  operation complete.
- `rd_req_o`  out  1  EOC read request.
- `rd_addr_o`  out  64  read address.
- `rd_gnt_i`  in  1  read request accepted.
- `rd_valid_i`  in  1  read data valid.
- `rd_data_i`  in  32  read data.
- `uart_busy_i`  in  1  UART is mid-byte.
- `done_o`  out  1  run finished; level output.
- `exit_code_o`  out  32  exit code.
- `error_o`  out  1  unsupported configuration; level output.

## Operation
- IDLE: on `start_i`, latch `boot_mode_i`, `preload_mode_i` and `snitch_preload_i`, then go to CFG.
- CFG: drive `boot_mode_o` with the latched boot mode, then go to WAIT_RST.
  - Boot mode 1 goes to ERROR instead.
  - Preload mode 2 with the Snitch preload flag set goes to ERROR instead.
- WAIT_RST: wait until the synchronised `dut_rst_ni` is 1.
- Operation sequence by mode:
  - Boot mode 0, preload mode 0: INIT(JTAG) → [SNITCH_PRELOAD(JTAG)] → RUN(JTAG) → POLL over JTAG.
  - Boot mode 0, preload mode 1: [SNITCH_PRELOAD(SLINK)] → RUN(SLINK) → POLL over SLINK.
  - Boot mode 0, preload mode 2: RUN(UART) → POLL over UART.
  - Boot mode 0, preload mode 3: INIT(JTAG) → [SNITCH_PRELOAD(FAST)] → RUN(JTAG) → POLL over JTAG.
  - Boot mode 2 or 3: INIT(JTAG) → POLL over JTAG.
  - Operations in brackets are issued only if the Snitch preload flag is set.
- OP state: assert `ld_req_o` with `ld_op_o`/`ld_if_o` until `ld_done_i` is sampled, then move to the next operation.
- POLL: `ld_if_o` keeps the poll transport. Assert `rd_req_o` with `rd_addr_o = EocAddr` until `rd_gnt_i`, then wait for `rd_valid_i`.
  - If `rd_data_i[0]` is 1: capture `exit_code_o = {1'b0, rd_data_i[31:1]}` and go to DRAIN.
  - Otherwise: wait `PollGap` cycles, then poll again.
- DRAIN: wait until `uart_busy_i` is 0, then go to DONE.
- DONE and ERROR hold until reset; `start_i` is ignored in both.
- Nonzero exit code = test failure. This is the bench's interpretation; the block takes no action on it.

## Timing
- Reset values: every output 0 except `rd_addr_o = EocAddr`; FSM in IDLE.
- `boot_mode_o` is registered and updates the cycle after CFG. It holds its value through DONE and ERROR.
- Request rules:
  - `ld_req_o` rises the cycle after entering an OP state and drops the cycle after `ld_done_i`.
  - `ld_done_i` asserted in the same cycle the request rises counts.
  - `ld_done_i` asserted while no request is outstanding is ignored.
- Read rules:
  - `rd_req_o` holds until `rd_gnt_i`. Grant and valid may arrive in the same cycle.
  - Only one read is outstanding at a time.
  - `rd_valid_i` while not waiting for data is ignored.
- `exit_code_o` and `done_o` update in the same cycle.
- Assertion of `rst_ni` at any point returns the FSM to IDLE and clears all outputs asynchronously.
- If `dut_rst_ni` falls after WAIT_RST, the sequence does not restart.

## Structure
- Shared package `picobello_fixture_pkg`: `boot_mode_e`, `preload_mode_e` (= transport), `ld_op_e`, the FSM state enum, and `EocDoneBit = 0`.
- One sub-module: `eoc_poller`, which covers the read handshake, the gap counter and exit-code extraction.

## Test plan
- Boot mode 0, preload mode 0, Snitch preload set → ops INIT/JTAG, SNITCH_PRELOAD/JTAG, RUN/JTAG in order. EOC reads return 0, 0, then `0x0000_0001` → `done_o` = 1, `exit_code_o` = 0, exactly 3 reads spaced ≥ 16 cycles apart.
- Boot mode 0, preload mode 3, Snitch preload set → SNITCH_PRELOAD on FAST, RUN on JTAG. EOC read returns `0x0000_0007` → `exit_code_o` = 3.
- Boot mode 0, preload mode 2, Snitch preload set → `error_o` = 1 and no `ld_req_o`. Same setup with boot mode 1 → `error_o` = 1.
- Boot mode 2 → only INIT/JTAG, then polling. `boot_mode_o` = 2. `dut_rst_ni` held low 50 cycles → no request before release + 2 cycles.
- EOC done while `uart_busy_i` is held high 20 cycles → `done_o` rises the cycle after `uart_busy_i` falls.
- `rst_ni` asserted during POLL → all outputs 0 immediately; a new `start_i` restarts the sequence cleanly.

Source files
------------

// File: rtl/picobello_fixture_pkg.sv
// Shared types for the Picobello boot/preload fixture sequencer.
// Also holds the op-sequencing helper used by the top-level FSM.
package picobello_fixture_pkg;

    typedef enum logic [1:0] {
        BootPreload = 2'd0,
        BootSdCard  = 2'd1,
        BootAutoA   = 2'd2,
        BootAutoB   = 2'd3
    } boot_mode_e;

    // Also used as the loader transport encoding.
    typedef enum logic [1:0] {
        PreloadJtag  = 2'd0,
        PreloadSlink = 2'd1,
        PreloadUart  = 2'd2,
        PreloadFast  = 2'd3
    } preload_mode_e;

    typedef enum logic [1:0] {
        OpInit          = 2'd0,
        OpSnitchPreload = 2'd1,
        OpRun           = 2'd2
    } ld_op_e;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCfg     = 3'd1,
        StWaitRst = 3'd2,
        StOp      = 3'd3,
        StPoll    = 3'd4,
        StDrain   = 3'd5,
        StDone    = 3'd6,
        StError   = 3'd7
    } fixture_state_e;

    typedef enum logic [1:0] {
        PollIdle  = 2'd0,
        PollReq   = 2'd1,
        PollWait  = 2'd2,
        PollSleep = 2'd3
    } poll_state_e;

    localparam int unsigned EocDoneBit = 0;

    typedef struct packed {
        logic          poll;
        ld_op_e        op;
        preload_mode_e tp;
    } ld_step_t;

    // Next loader step; with first set, the step issued right after chip reset release.
    // A poll step keeps the current op and carries the poll transport.
    function automatic ld_step_t next_step(input logic          first,
                                           input ld_op_e        cur,
                                           input boot_mode_e    bm,
                                           input preload_mode_e pm,
                                           input logic          snitch);
        ld_step_t      s;
        preload_mode_e run_tp;
        logic          autonomous;
        autonomous = (bm != BootPreload);
        run_tp     = (pm == PreloadFast) ? PreloadJtag : pm;
        s.poll     = 1'b0;
        s.op       = cur;
        s.tp       = run_tp;
        if (first) begin
            if (autonomous || pm == PreloadJtag || pm == PreloadFast) begin
                s.op = OpInit;
                s.tp = PreloadJtag;
            end else if (pm == PreloadSlink && snitch) begin
                s.op = OpSnitchPreload;
            end else begin
                s.op = OpRun;
            end
        end else begin
            case (cur)
                OpInit: begin
                    if (autonomous) begin
                        s.poll = 1'b1;
                        s.tp   = PreloadJtag;
                    end else if (snitch) begin
                        s.op = OpSnitchPreload;
                        s.tp = (pm == PreloadFast) ? PreloadFast : PreloadJtag;
                    end else begin
                        s.op = OpRun;
                    end
                end
                OpSnitchPreload: s.op = OpRun;
                default:         s.poll = 1'b1;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/eoc_poller.sv
// EOC register poller: one read at a time, fixed idle gap between polls,
// exit code extracted from the upper 31 bits once the done bit is seen.
module eoc_poller
    import picobello_fixture_pkg::*;
#(
    parameter int unsigned PollGap = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    output logic        rd_req_o,
    input  logic        rd_gnt_i,
    input  logic        rd_valid_i,
    input  logic [31:0] rd_data_i,
    output logic        hit_o,
    output logic [31:0] exit_code_o
);

    localparam int unsigned CntW = (PollGap > 1) ? $clog2(PollGap) : 1;
    localparam logic [CntW-1:0] GapLoad = CntW'(PollGap - 1);

    poll_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     exit_q, exit_d;
    logic            data_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exit_d  = exit_q;
        hit_o   = 1'b0;
        data_ok = 1'b0;
        case (state_q)
            PollIdle: if (enable_i) state_d = PollReq;
            PollReq: begin
                if (rd_gnt_i) begin
                    if (rd_valid_i) data_ok = 1'b1;
                    else            state_d = PollWait;
                end
            end
            PollWait: if (rd_valid_i) data_ok = 1'b1;
            default: begin
                if (cnt_q == '0) state_d = PollReq;
                else             cnt_d   = cnt_q - 1'b1;
            end
        endcase
        if (data_ok) begin
            if (rd_data_i[EocDoneBit]) begin
                hit_o   = 1'b1;
                exit_d  = {1'b0, rd_data_i[31:1]};
                state_d = PollIdle;
            end else begin
                state_d = PollSleep;
                cnt_d   = GapLoad;
            end
        end
        if (!enable_i) state_d = PollIdle;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= PollIdle;
            cnt_q   <= '0;
            exit_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exit_q  <= exit_d;
        end
    end

    assign rd_req_o    = (state_q == PollReq);
    assign exit_code_o = exit_q;

endmodule

// File: rtl/picobello_top_fixture.sv
// Boot/preload sequencer for the Picobello top-level fixture: sets boot pins,
// waits for chip reset release, dispatches loader ops, then polls EOC.
module picobello_top_fixture
    import picobello_fixture_pkg::*;
#(
    parameter logic [63:0] EocAddr = 64'h0300_0008,
    parameter int unsigned PollGap = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [1:0]  boot_mode_i,
    input  logic [1:0]  preload_mode_i,
    input  logic        snitch_preload_i,
    output logic [1:0]  boot_mode_o,
    input  logic        dut_rst_ni,
    output logic        ld_req_o,
    output logic [1:0]  ld_op_o,
    output logic [1:0]  ld_if_o,
    input  logic        ld_done_i,
    output logic        rd_req_o,
    output logic [63:0] rd_addr_o,
    input  logic        rd_gnt_i,
    input  logic        rd_valid_i,
    input  logic [31:0] rd_data_i,
    input  logic        uart_busy_i,
    output logic        done_o,
    output logic [31:0] exit_code_o,
    output logic        error_o
);

    fixture_state_e state_q, state_d;
    boot_mode_e     bm_q, bm_d;
    preload_mode_e  pm_q, pm_d;
    logic           snitch_q, snitch_d;
    logic [1:0]     boot_mode_q, boot_mode_d;
    logic           ld_req_q, ld_req_d;
    ld_op_e         op_q, op_d;
    preload_mode_e  if_q, if_d;
    logic           done_q, done_d;
    logic [31:0]    exit_q, exit_d;
    logic           error_q, error_d;
    logic [1:0]     sync_q;
    ld_step_t       step;
    logic           poll_hit;
    logic [31:0]    poll_exit;

    always_comb begin
        state_d     = state_q;
        bm_d        = bm_q;
        pm_d        = pm_q;
        snitch_d    = snitch_q;
        boot_mode_d = boot_mode_q;
        ld_req_d    = ld_req_q;
        op_d        = op_q;
        if_d        = if_q;
        done_d      = done_q;
        exit_d      = exit_q;
        error_d     = error_q;
        step        = next_step(state_q == StWaitRst, op_q, bm_q, pm_q, snitch_q);
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    bm_d     = boot_mode_e'(boot_mode_i);
                    pm_d     = preload_mode_e'(preload_mode_i);
                    snitch_d = snitch_preload_i;
                    state_d  = StCfg;
                end
            end
            StCfg: begin
                boot_mode_d = bm_q;
                if (bm_q == BootSdCard || (pm_q == PreloadUart && snitch_q)) begin
                    state_d = StError;
                    error_d = 1'b1;
                end else begin
                    state_d = StWaitRst;
                end
            end
            StWaitRst: begin
                if (sync_q[1]) begin
                    op_d    = step.op;
                    if_d    = step.tp;
                    state_d = step.poll ? StPoll : StOp;
                end
            end
            StOp: begin
                // Done only counts against a visible request; the gap cycle re-arms the next op.
                if (ld_req_q && ld_done_i) begin
                    ld_req_d = 1'b0;
                    op_d     = step.op;
                    if_d     = step.tp;
                    state_d  = step.poll ? StPoll : StOp;
                end else begin
                    ld_req_d = 1'b1;
                end
            end
            StPoll: if (poll_hit) state_d = StDrain;
            StDrain: begin
                if (!uart_busy_i) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    exit_d  = poll_exit;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            bm_q        <= BootPreload;
            pm_q        <= PreloadJtag;
            snitch_q    <= 1'b0;
            boot_mode_q <= 2'd0;
            ld_req_q    <= 1'b0;
            op_q        <= OpInit;
            if_q        <= PreloadJtag;
            done_q      <= 1'b0;
            exit_q      <= '0;
            error_q     <= 1'b0;
            sync_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            bm_q        <= bm_d;
            pm_q        <= pm_d;
            snitch_q    <= snitch_d;
            boot_mode_q <= boot_mode_d;
            ld_req_q    <= ld_req_d;
            op_q        <= op_d;
            if_q        <= if_d;
            done_q      <= done_d;
            exit_q      <= exit_d;
            error_q     <= error_d;
            sync_q      <= {sync_q[0], dut_rst_ni};
        end
    end

    eoc_poller #(
        .PollGap (PollGap)
    ) u_eoc_poller (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .enable_i    (state_q == StPoll),
        .rd_req_o    (rd_req_o),
        .rd_gnt_i    (rd_gnt_i),
        .rd_valid_i  (rd_valid_i),
        .rd_data_i   (rd_data_i),
        .hit_o       (poll_hit),
        .exit_code_o (poll_exit)
    );

    assign boot_mode_o = boot_mode_q;
    assign ld_req_o    = ld_req_q;
    assign ld_op_o     = op_q;
    assign ld_if_o     = if_q;
    assign rd_addr_o   = EocAddr;
    assign done_o      = done_q;
    assign exit_code_o = exit_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_picobello_top_fixture.sv
// Bench for picobello_top_fixture: loader and EOC-read responders with an
// expected-op scoreboard, plus directed boot/preload scenarios.
module tb_picobello_top_fixture;

    localparam logic [63:0] EocAddr = 64'h0300_0008;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  boot_mode_in = 2'd0;
    logic [1:0]  preload_mode = 2'd0;
    logic        snitch = 1'b0;
    logic [1:0]  boot_mode_out;
    logic        chip_rst_n = 1'b1;
    logic        ld_req;
    logic [1:0]  ld_op;
    logic [1:0]  ld_if;
    logic        ld_done = 1'b0;
    logic        rd_req;
    logic [63:0] rd_addr;
    logic        rd_gnt = 1'b0;
    logic        rd_valid = 1'b0;
    logic [31:0] rd_data = '0;
    logic        uart_busy = 1'b0;
    logic        done;
    logic [31:0] exit_code;
    logic        error;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          n_ld = 0;
    int          n_reads = 0;
    int          first_ld_cyc = -1;
    logic        rd_split = 1'b0;
    logic        rd_ph = 1'b0;
    logic [31:0] rd_hold = '0;
    logic [3:0]  exp_ld[$];
    logic [31:0] rd_q[$];
    int          rd_cyc[$];

    picobello_top_fixture #(
        .EocAddr (EocAddr),
        .PollGap (16)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .start_i          (start),
        .boot_mode_i      (boot_mode_in),
        .preload_mode_i   (preload_mode),
        .snitch_preload_i (snitch),
        .boot_mode_o      (boot_mode_out),
        .dut_rst_ni       (chip_rst_n),
        .ld_req_o         (ld_req),
        .ld_op_o          (ld_op),
        .ld_if_o          (ld_if),
        .ld_done_i        (ld_done),
        .rd_req_o         (rd_req),
        .rd_addr_o        (rd_addr),
        .rd_gnt_i         (rd_gnt),
        .rd_valid_i       (rd_valid),
        .rd_data_i        (rd_data),
        .uart_busy_i      (uart_busy),
        .done_o           (done),
        .exit_code_o      (exit_code),
        .error_o          (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Loader and EOC-read agents; expected ops are popped as requests appear.
    always @(negedge clk) begin
        logic [3:0]  e;
        logic [31:0] d;
        if (!rst_n) begin
            ld_done  = 1'b0;
            rd_gnt   = 1'b0;
            rd_valid = 1'b0;
            rd_ph    = 1'b0;
        end else begin
            if (ld_done) begin
                ld_done = 1'b0;
            end else if (ld_req) begin
                n_ld++;
                if (first_ld_cyc < 0) first_ld_cyc = cyc;
                if (exp_ld.size() == 0) begin
                    check("ld_unexpected", {60'd0, ld_op, ld_if}, 64'hf);
                end else begin
                    e = exp_ld.pop_front();
                    check("ld_op", 64'(ld_op), 64'(e[3:2]));
                    check("ld_if", 64'(ld_if), 64'(e[1:0]));
                end
                ld_done = 1'b1;
            end
            rd_gnt   = 1'b0;
            rd_valid = 1'b0;
            if (rd_ph) begin
                rd_valid = 1'b1;
                rd_data  = rd_hold;
                rd_ph    = 1'b0;
            end else if (rd_req) begin
                n_reads++;
                rd_cyc.push_back(cyc);
                check("rd_addr", rd_addr, EocAddr);
                d = (rd_q.size() != 0) ? rd_q.pop_front() : 32'd0;
                rd_gnt = 1'b1;
                if (rd_split) begin
                    rd_hold = d;
                    rd_ph   = 1'b1;
                end else begin
                    rd_valid = 1'b1;
                    rd_data  = d;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        uart_busy = 1'b0;
        chip_rst_n = 1'b1;
        rd_split = 1'b0;
        exp_ld.delete();
        rd_q.delete();
        rd_cyc.delete();
        n_ld = 0;
        n_reads = 0;
        first_ld_cyc = -1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic kick(input logic [1:0] bm, input logic [1:0] pm, input logic sn);
        @(negedge clk);
        boot_mode_in = bm;
        preload_mode = pm;
        snitch = sn;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int k = 0;
        while (!(done || error) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("end_timeout", 64'(done || error), 64'd1);
    endtask

    task automatic wait_reads(input int n, input int budget);
        int k = 0;
        while (n_reads < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("read_timeout", 64'(n_reads >= n), 64'd1);
    endtask

    initial begin
        int rel_cyc;
        int n_ld_snap;
        repeat (3) @(negedge clk);
        check("rst_boot_mode", 64'(boot_mode_out), 64'd0);
        check("rst_ld", {61'd0, ld_req, ld_op}, 64'd0);
        check("rst_ld_if", 64'(ld_if), 64'd0);
        check("rst_rd_req", 64'(rd_req), 64'd0);
        check("rst_rd_addr", rd_addr, EocAddr);
        check("rst_status", {31'd0, done, exit_code}, 64'd0);
        check("rst_error", 64'(error), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Boot 0 / JTAG with Snitch preload; EOC set on the third read.
        exp_ld.push_back({2'd0, 2'd0});
        exp_ld.push_back({2'd1, 2'd0});
        exp_ld.push_back({2'd2, 2'd0});
        rd_q.push_back(32'd0);
        rd_q.push_back(32'd0);
        rd_q.push_back(32'd1);
        kick(2'd0, 2'd0, 1'b1);
        wait_end(2000);
        check("s1_done", 64'(done), 64'd1);
        check("s1_exit", 64'(exit_code), 64'd0);
        check("s1_poll_if", 64'(ld_if), 64'd0);
        check("s1_ops_left", 64'(exp_ld.size()), 64'd0);
        n_ld_snap = n_ld;
        kick(2'd2, 2'd1, 1'b0);
        repeat (30) @(negedge clk);
        check("s1_reads", 64'(n_reads), 64'd3);
        for (int i = 1; i < rd_cyc.size(); i++)
            check("s1_poll_gap", 64'(rd_cyc[i] - rd_cyc[i-1] >= 16), 64'd1);
        check("s1_start_ignored", {31'd0, done, 32'(n_ld)}, {31'd0, 1'b1, 32'(n_ld_snap)});

        // Boot 0 / fast preload; data valid a cycle after grant.
        do_reset();
        rd_split = 1'b1;
        exp_ld.push_back({2'd0, 2'd0});
        exp_ld.push_back({2'd1, 2'd3});
        exp_ld.push_back({2'd2, 2'd0});
        rd_q.push_back(32'h0000_0007);
        kick(2'd0, 2'd3, 1'b1);
        wait_end(2000);
        check("s2_exit", 64'(exit_code), 64'd3);
        check("s2_done", 64'(done), 64'd1);
        check("s2_ops_left", 64'(exp_ld.size()), 64'd0);

        // UART preload with Snitch flag is unsupported.
        do_reset();
        kick(2'd0, 2'd2, 1'b1);
        wait_end(200);
        repeat (10) @(negedge clk);
        check("s3_error", {62'd0, error, done}, 64'd2);
        check("s3_no_ld", 64'(n_ld), 64'd0);

        // SD-card boot is unsupported.
        do_reset();
        kick(2'd1, 2'd0, 1'b0);
        wait_end(200);
        repeat (5) @(negedge clk);
        check("s3b_error", {62'd0, error, done}, 64'd2);
        check("s3b_no_ld", 64'(n_ld), 64'd0);

        // Autonomous boot with chip reset held low for 50 cycles.
        do_reset();
        chip_rst_n = 1'b0;
        exp_ld.push_back({2'd0, 2'd0});
        rd_q.push_back(32'h0000_0003);
        kick(2'd2, 2'd1, 1'b1);
        repeat (50) @(negedge clk);
        check("s4_held_no_ld", 64'(n_ld), 64'd0);
        check("s4_boot_mode", 64'(boot_mode_out), 64'd2);
        rel_cyc = cyc;
        chip_rst_n = 1'b1;
        wait_end(2000);
        check("s4_after_release", 64'(first_ld_cyc >= rel_cyc + 2), 64'd1);
        check("s4_exit", 64'(exit_code), 64'd1);
        check("s4_poll_if", 64'(ld_if), 64'd0);
        check("s4_ops_left", 64'(exp_ld.size()), 64'd0);
        check("s4_boot_mode_hold", 64'(boot_mode_out), 64'd2);

        // Serial link, no Snitch preload; UART busy holds completion for 20 cycles.
        do_reset();
        uart_busy = 1'b1;
        exp_ld.push_back({2'd2, 2'd1});
        rd_q.push_back(32'h0000_0001);
        kick(2'd0, 2'd1, 1'b0);
        wait_reads(1, 2000);
        repeat (20) @(negedge clk);
        check("s5_drain_hold", 64'(done), 64'd0);
        check("s5_poll_if", 64'(ld_if), 64'd1);
        uart_busy = 1'b0;
        @(posedge clk);
        #1;
        check("s5_drain_rise", 64'(done), 64'd1);
        check("s5_exit", 64'(exit_code), 64'd0);

        // Reset asserted mid-poll, then a clean restart.
        do_reset();
        exp_ld.push_back({2'd2, 2'd2});
        kick(2'd0, 2'd2, 1'b0);
        wait_reads(2, 2000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_rst_ld", {60'd0, ld_req, ld_op, ld_if}, 64'd0);
        check("s6_rst_rd", 64'(rd_req), 64'd0);
        check("s6_rst_outs", {29'd0, done, error, boot_mode_out, exit_code}, 64'd0);
        do_reset();
        exp_ld.push_back({2'd2, 2'd2});
        rd_q.push_back(32'h0000_000b);
        kick(2'd0, 2'd2, 1'b0);
        wait_end(2000);
        check("s6_exit", 64'(exit_code), 64'd5);
        check("s6_poll_if", 64'(ld_if), 64'd2);
        check("s6_reads", 64'(n_reads), 64'd1);
        check("s6_ops_left", 64'(exp_ld.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
